// File: rtl/logic_seg_pkg.sv
// Shared definitions for the logic unit: mode encodings and the
// active-low seven-segment hex decoder used by every display digit.
package logic_seg_pkg;

  typedef logic [2:0] modeT;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam int         MODE_COUNT = 6;

  // Segment order {g,f,e,d,c,b,a}, 0 = segment lit.
  function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability debounce, and a
// one-cycle press pulse on an accepted released->pressed transition.
module btn_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic press
);

  localparam int              CNT_W  = $clog2(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE - 1);

  logic             btnMeta;
  logic             btnSync;
  logic             btnLevel;
  logic [CNT_W-1:0] stableCnt;
  logic             levelDiffers;
  logic             accept;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one; going back to the accepted level is the "level change"
  // that restarts it, so bounces never reach terminal count.
  assign levelDiffers = (btnSync != btnLevel);
  assign accept       = levelDiffers && (stableCnt == CNT_TC);

  // Synchronize the raw button; idle (released) level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnMeta <= 1'b1;
      btnSync <= 1'b1;
    end else begin
      btnMeta <= btnRaw;
      btnSync <= btnMeta;
    end
  end

  // Count consecutive cycles the new level has held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stableCnt <= '0;
    end else if (!levelDiffers || accept) begin
      stableCnt <= '0;
    end else begin
      stableCnt <= stableCnt + 1'b1;
    end
  end

  // Take over the new level once it has been stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnLevel <= 1'b1;
    end else if (accept) begin
      btnLevel <= btnSync;
    end
  end

  // Pulse only when the accepted level falls to 0 (pressed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press <= 1'b0;
    end else begin
      press <= accept && !btnSync;
    end
  end

endmodule

// File: rtl/logic_unit_seg.sv
// Switch-driven bitwise logic unit with a push-button mode selector and
// seven-segment display of A, B, the result and the current mode.
//
// state | meaning
// AND   | result = a & b
// OR    | result = a | b
// XOR   | result = a ^ b
// NAND  | result = ~(a & b)
// NOR   | result = ~(a | b)
// XNOR  | result = ~(a ^ b), next press wraps to AND
module logic_unit_seg #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             modeBtn,
  output logic [6:0]       segA,
  output logic [6:0]       segB,
  output logic [6:0]       segOut,
  output logic [6:0]       segMode,
  output logic [WIDTH-1:0] ledOut
);
  import logic_seg_pkg::*;

  logic [WIDTH-1:0] aMeta, aSync, bMeta, bSync;
  logic [WIDTH-1:0] aReg, bReg, resultNext, resultReg;
  logic             press;
  modeT             mode;
  modeT             modeShown;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) uDebounce (
    .clk    (clk),
    .rst    (rst),
    .btnRaw (modeBtn),
    .press  (press)
  );

  // Two-flop synchronizers for the switch operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aMeta <= '0;
      aSync <= '0;
      bMeta <= '0;
      bSync <= '0;
    end else begin
      aMeta <= a;
      aSync <= aMeta;
      bMeta <= b;
      bSync <= bMeta;
    end
  end

  // Mode FSM: each press advances one state, XNOR wraps to AND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= MODE_AND;
    end else if (press) begin
      mode <= (mode == MODE_XNOR) ? MODE_AND : mode + 3'd1;
    end
  end

  // Bitwise operation selected by the current mode.
  always_comb begin
    resultNext = '0;
    case (mode)
      MODE_AND:  resultNext = aSync & bSync;
      MODE_OR:   resultNext = aSync | bSync;
      MODE_XOR:  resultNext = aSync ^ bSync;
      MODE_NAND: resultNext = ~(aSync & bSync);
      MODE_NOR:  resultNext = ~(aSync | bSync);
      MODE_XNOR: resultNext = ~(aSync ^ bSync);
      default:   resultNext = '0;
    endcase
  end

  // Output registers; the mode digit is registered alongside the result
  // so the display never shows a mode whose result is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg      <= '0;
      bReg      <= '0;
      resultReg <= '0;
      modeShown <= MODE_AND;
    end else begin
      aReg      <= aSync;
      bReg      <= bSync;
      resultReg <= resultNext;
      modeShown <= mode;
    end
  end

  assign segA    = hexToSeg(4'(aReg));
  assign segB    = hexToSeg(4'(bReg));
  assign segOut  = hexToSeg(4'(resultReg));
  assign segMode = hexToSeg({1'b0, modeShown});
  assign ledOut  = resultReg;

endmodule

// File: tb/tb_logic_unit_seg.sv
// Self-checking bench for logic_unit_seg: a cycle-level behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_logic_unit_seg;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       modeBtn = 1'b1;

  logic [6:0] segA, segB, segOut, segMode;
  logic [3:0] ledOut;
  logic [6:0] segA1, segB1, segOut1, segMode1;
  logic [0:0] ledOut1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_seg #(.WIDTH(4), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .modeBtn(modeBtn),
    .segA(segA), .segB(segB), .segOut(segOut), .segMode(segMode), .ledOut(ledOut)
  );

  logic_unit_seg #(.WIDTH(1), .DEBOUNCE(DB)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .modeBtn(modeBtn),
    .segA(segA1), .segB(segB1), .segOut(segOut1), .segMode(segMode1), .ledOut(ledOut1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int refSeg(input int v);
    case (v)
      0: return int'(7'b1000000);   1: return int'(7'b1111001);
      2: return int'(7'b0100100);   3: return int'(7'b0110000);
      4: return int'(7'b0011001);   5: return int'(7'b0010010);
      6: return int'(7'b0000010);   7: return int'(7'b1111000);
      8: return int'(7'b0000000);   9: return int'(7'b0010000);
      10: return int'(7'b0001000);  11: return int'(7'b0000011);
      12: return int'(7'b1000110);  13: return int'(7'b0100001);
      14: return int'(7'b0000110);  15: return int'(7'b0001110);
      default: return -1;
    endcase
  endfunction

  function automatic int logicOp(input int m, input int x, input int y);
    case (m)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return (~(x & y)) & 15;
      4: return (~(x | y)) & 15;
      5: return (~(x ^ y)) & 15;
      default: return -1;
    endcase
  endfunction

  // Model state: what the design has seen, what it has accepted, and what
  // it must display after the most recent clock edge.
  logic rawDly [2];
  int   aDly [2];
  int   bDly [2];
  logic win [DB];
  logic acc;
  logic pressPrev;
  int   modeIdx;
  int   expA, expB, expRes, expMode;

  task automatic modelReset();
    rawDly[0] = 1'b1; rawDly[1] = 1'b1;
    aDly[0] = 0; aDly[1] = 0;
    bDly[0] = 0; bDly[1] = 0;
    for (int i = 0; i < DB; i++) win[i] = 1'b1;
    acc = 1'b1;
    pressPrev = 1'b0;
    modeIdx = 0;
    expA = 0; expB = 0; expRes = 0; expMode = 0;
  endtask

  task automatic modelStep();
    logic s;
    logic allDiff;
    logic pressNow;
    int   aNow, bNow;
    s = rawDly[0]; rawDly[0] = rawDly[1]; rawDly[1] = modeBtn;
    aNow = aDly[0]; aDly[0] = aDly[1]; aDly[1] = int'(a);
    bNow = bDly[0]; bDly[0] = bDly[1]; bDly[1] = int'(b);
    for (int i = 0; i < DB - 1; i++) win[i] = win[i+1];
    win[DB-1] = s;
    allDiff = 1'b1;
    for (int i = 0; i < DB; i++) if (win[i] == acc) allDiff = 1'b0;
    pressNow = 1'b0;
    if (allDiff) begin
      acc = ~acc;
      pressNow = !acc;
    end
    expMode = modeIdx;
    expA    = aNow;
    expB    = bNow;
    expRes  = logicOp(modeIdx, aNow, bNow);
    if (pressPrev) modeIdx = (modeIdx + 1) % 6;
    pressPrev = pressNow;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else     modelStep();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("segA",    int'(segA),    refSeg(expA));
      check("segB",    int'(segB),    refSeg(expB));
      check("segOut",  int'(segOut),  refSeg(expRes));
      check("ledOut",  int'(ledOut),  expRes);
      check("segMode", int'(segMode), refSeg(expMode));
    end
  end

  task automatic pressBtn(input int holdLow, input int holdHigh);
    @(negedge clk); modeBtn = 1'b0;
    repeat (holdLow) @(negedge clk);
    modeBtn = 1'b1;
    repeat (holdHigh) @(negedge clk);
  endtask

  int modeSeq [6] = '{1, 2, 3, 4, 5, 0};
  int ledSeq  [6] = '{14, 6, 7, 1, 9, 8};

  initial begin
    @(posedge clk); #1;
    check("rst_segA",    int'(segA),    int'(7'b1000000));
    check("rst_segMode", int'(segMode), int'(7'b1000000));
    check("rst_ledOut",  int'(ledOut),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Three-cycle operand latency, AND mode.
    a = 4'hC; b = 4'hA;
    repeat (2) @(posedge clk); #1;
    check("lat2_ledOut", int'(ledOut), 0);
    @(posedge clk); #1;
    check("lat3_ledOut", int'(ledOut), 8);
    check("lat3_segOut", int'(segOut), int'(7'b0000000));

    // Six clean presses walk through every mode and wrap to AND.
    for (int i = 0; i < 6; i++) begin
      pressBtn(10, 10);
      #1;
      check("walk_ledOut",  int'(ledOut),  ledSeq[i]);
      check("walk_segMode", int'(segMode), refSeg(modeSeq[i]));
    end

    // Bounce shorter than the debounce window: mode must hold at OR.
    pressBtn(10, 10);
    for (int i = 0; i < 10; i++) begin
      modeBtn = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    modeBtn = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("bounce_ledOut",  int'(ledOut),  14);
    check("bounce_segMode", int'(segMode), refSeg(1));

    // Asynchronous reset mid-run, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("arst_segA",    int'(segA),    int'(7'b1000000));
    check("arst_segB",    int'(segB),    int'(7'b1000000));
    check("arst_segOut",  int'(segOut),  int'(7'b1000000));
    check("arst_segMode", int'(segMode), int'(7'b1000000));
    check("arst_ledOut",  int'(ledOut),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Minimum-length press is accepted; a second press is cut by reset.
    pressBtn(4, 10);
    #1;
    check("min_press_segMode", int'(segMode), refSeg(1));
    @(negedge clk); modeBtn = 1'b0;
    repeat (4) @(negedge clk);
    check("cut_press_segMode", int'(segMode), refSeg(1));
    rst = 1'b1; modeBtn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("cut_press_after_segMode", int'(segMode), refSeg(0));
    check("cut_press_after_ledOut",  int'(ledOut),  8);

    // Narrow instance in XOR mode.
    a1 = 1'b1; b1 = 1'b0;
    pressBtn(10, 10);
    pressBtn(10, 10);
    #1;
    check("w1_segA",   int'(segA1),   int'(7'b1111001));
    check("w1_segB",   int'(segB1),   int'(7'b1000000));
    check("w1_segOut", int'(segOut1), int'(7'b1111001));
    check("w1_ledOut", int'(ledOut1), 1);
    check("w4_xor_ledOut", int'(ledOut), 6);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
